ps2_scan_controller: RTL and testbench

//  Sequences the PS/2 keyboard receive path entirely in the CLOCK_50 domain.

---
 rtl/ps2_pkg.sv | 7 +
 rtl/ps2_frame_rx.sv | 83 ++++++++
 rtl/ps2_scan_controller.sv | 70 +++++++
 tb/tb_ps2_scan_controller.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared prefix codes, frame states and scan-code type for the PS/2 receive path
package ps2_pkg;
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_frame_state_t;
    typedef logic [15:0] ps2_scan_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and deglitches the PS/2 pins, then assembles 11-bit frames
import ps2_pkg::*;
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [1:0]            r_clk_sync, r_dat_sync;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk, r_strobe, r_perr;
    ps2_frame_state_t      r_state;
    logic [2:0]            r_bitcnt;
    logic [7:0]            r_sh;
    logic [TW-1:0]         r_tmo;
    logic                  w_dat;
    assign w_dat  = r_dat_sync[1];
    assign o_byte = r_sh;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_filt     <= '1;
            r_fclk     <= 1'b1;
            r_strobe   <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
            r_filt     <= {r_filt[FILTER_LEN-2:0], r_clk_sync[1]};
            r_fclk     <= &r_filt ? 1'b1 : ~|r_filt ? 1'b0 : r_fclk;
            r_strobe   <= r_fclk & ~|r_filt;
        end
    end
    // The timeout counts cycles since the last strobe; it only matters mid-frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_bitcnt     <= '0;
            r_sh         <= '0;
            r_perr       <= 1'b0;
            r_tmo        <= '0;
            o_byte_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_err        <= 1'b0;
            r_tmo        <= (r_strobe || r_state == IDLE) ? '0 : r_tmo + TW'(1);
            if (r_state != IDLE && !r_strobe && r_tmo == TMO_LAST) begin
                r_state <= IDLE;
                o_err   <= 1'b1;
            end else if (r_strobe) begin
                case (r_state)
                    IDLE: if (!w_dat) begin
                        r_state  <= DATA;
                        r_bitcnt <= '0;
                    end
                    DATA: begin
                        r_sh     <= {w_dat, r_sh[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= PARITY;
                    end
                    PARITY: begin
                        r_perr  <= ~(^r_sh ^ w_dat);
                        r_state <= STOP;
                    end
                    STOP: begin
                        o_byte_valid <= w_dat & ~r_perr;
                        o_err        <= ~w_dat | r_perr;
                        r_state      <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/ps2_scan_controller.sv
// ps2_scan_controller: folds E0/F0 prefixes into make codes, queues them and presents the head as rdata/irq
import ps2_pkg::*;
module ps2_scan_controller #(
    parameter int FILTER_LEN     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    output logic [15:0]                   io_rdata,
    output logic                          io_irq,
    input  logic                          io_reset_irq,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count,
    output logic                          frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic          w_valid, w_err, w_push, w_full, w_pop, w_wr;
    logic [7:0]    w_byte;
    logic [AW-1:0] w_rp_n;
    logic [CW-1:0] w_cnt_n;
    ps2_scan_t     w_entry, w_head;
    logic          r_ext, r_brk;
    logic [AW-1:0] r_wp, r_rp;
    ps2_scan_t     r_mem [FIFO_DEPTH];
    ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .i_clk(CLOCK_50), .i_rst_n(reset), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
        .o_byte_valid(w_valid), .o_byte(w_byte), .o_err(w_err)
    );
    assign w_push  = w_valid && w_byte != PS2_PREFIX_EXT && w_byte != PS2_PREFIX_BRK && !r_brk;
    assign w_entry = {r_ext ? PS2_PREFIX_EXT : 8'h00, w_byte};
    assign w_full  = fifo_count == CW'(FIFO_DEPTH);
    assign w_pop   = io_reset_irq && fifo_count != '0;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_rp_n  = r_rp + AW'(w_pop);
    assign w_cnt_n = fifo_count + CW'(w_wr) - CW'(w_pop);
    // A push into an otherwise-empty slot is forwarded so rdata is valid the next cycle.
    assign w_head  = w_cnt_n == '0 ? '0 : (w_wr && r_wp == w_rp_n) ? w_entry : r_mem[w_rp_n];
    always_ff @(posedge CLOCK_50) begin
        if (w_wr) r_mem[r_wp] <= w_entry;
    end
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_wp       <= '0;
            r_rp       <= '0;
            fifo_count <= '0;
            drop_count <= '0;
            frame_err  <= 1'b0;
            io_rdata   <= '0;
            io_irq     <= 1'b0;
        end else begin
            if (w_valid) begin
                r_ext <= w_byte == PS2_PREFIX_EXT ? 1'b1 : w_byte == PS2_PREFIX_BRK ? r_ext : 1'b0;
                r_brk <= w_byte == PS2_PREFIX_BRK ? 1'b1 : w_byte == PS2_PREFIX_EXT ? r_brk : 1'b0;
            end
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_push && w_full && !w_pop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            r_rp       <= w_rp_n;
            fifo_count <= w_cnt_n;
            frame_err  <= frame_err | w_err;
            io_rdata   <= w_head;
            io_irq     <= w_cnt_n != '0;
        end
    end
endmodule

// File: tb/tb_ps2_scan_controller.sv
// tb_ps2_scan_controller: directed and random PS/2 frames checked against a queue-based keyboard model
module tb_ps2_scan_controller;
    localparam int FL = 16, FD = 8, TC = 3000;
    logic clk = 0, rst_n = 0, kclk = 1, kdat = 1, ack = 0;
    logic [15:0] rdata;
    logic irq, ferr;
    logic [3:0] cnt;
    logic [7:0] drops;
    int tests = 0, fails = 0, cyc = 0, t_stop = 0, t_irq = 0;
    logic irq_prev = 0;
    logic [15:0] q[$];
    bit ext_m, brk_m, err_m;
    int drop_m;
    ps2_scan_controller #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TC)) dut (
        .CLOCK_50(clk), .reset(rst_n), .ps2_clk(kclk), .ps2_dat(kdat),
        .io_rdata(rdata), .io_irq(irq), .io_reset_irq(ack),
        .fifo_count(cnt), .drop_count(drops), .frame_err(ferr)
    );
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (irq === 1'b1 && irq_prev !== 1'b1) t_irq = cyc;
        irq_prev = irq;
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_all(input string tag);
        check({tag, "/rdata"}, 32'(rdata), q.size() != 0 ? 32'(q[0]) : 32'h0);
        check({tag, "/irq"}, 32'(irq), 32'(q.size() != 0));
        check({tag, "/count"}, 32'(cnt), 32'(q.size()));
        check({tag, "/drops"}, 32'(drops), 32'(drop_m));
        check({tag, "/ferr"}, 32'(ferr), 32'(err_m));
    endtask
    function automatic void model_rx(input logic [7:0] b);
        if (b == 8'hE0) ext_m = 1;
        else if (b == 8'hF0) brk_m = 1;
        else begin
            if (!brk_m) begin
                if (q.size() < FD) q.push_back({ext_m ? 8'hE0 : 8'h00, b});
                else if (drop_m < 255) drop_m++;
            end
            ext_m = 0;
            brk_m = 0;
        end
    endfunction
    task automatic send_frame(input logic [7:0] b, input bit flip, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kdat = f[i];
            tick(15);
            kclk = 0;
            if (i == 10) t_stop = cyc;
            tick(30);
            kclk = 1;
            tick(15);
        end
        kdat = 1;
    endtask
    task automatic good(input logic [7:0] b, input string tag);
        send_frame(b, 0, 11);
        model_rx(b);
        check_all(tag);
    endtask
    task automatic pop(input string tag);
        ack = 1;
        tick(1);
        ack = 0;
        if (q.size() != 0) void'(q.pop_front());
        check_all(tag);
    endtask
    task automatic model_reset();
        q.delete();
        ext_m = 0;
        brk_m = 0;
        err_m = 0;
        drop_m = 0;
    endtask
    initial begin
        logic [7:0] b;
        model_reset();
        tick(3);
        check_all("reset");
        rst_n = 1;
        tick(5);
        good(8'h1C, "make1c");
        check("latency", 32'((t_irq - t_stop) <= FL + 5 && t_irq > t_stop), 32'h1);
        pop("pop1c");
        good(8'hE0, "e0");
        good(8'h75, "e075");
        good(8'hE0, "e0b");
        good(8'hF0, "e0f0");
        good(8'h75, "e0f075");
        pop("pope075");
        good(8'hF0, "f0");
        good(8'h1C, "f01c");
        good(8'h1C, "after_brk");
        pop("pop_after_brk");
        send_frame(8'h1C, 1, 11);
        err_m = 1;
        check_all("bad_parity");
        good(8'h29, "after_perr");
        pop("pop29");
        for (int i = 0; i < 9; i++) good(8'(8'h15 + i), "fill");
        for (int i = 0; i < 8; i++) pop("drain");
        ack = 1;
        send_frame(8'h33, 0, 11);
        tick(2);
        ack = 0;
        model_rx(8'h33);
        void'(q.pop_front());
        check_all("ack_held");
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 9))
                0: b = 8'hE0;
                1: b = 8'hF0;
                default: b = 8'($urandom_range(1, 127));
            endcase
            good(b, "rand");
            if ($urandom_range(0, 2) == 0) pop("rand_pop");
        end
        good(8'hE0, "pre_reset_e0");
        send_frame(8'h5A, 0, 4);
        rst_n = 0;
        model_reset();
        tick(2);
        check_all("mid_reset");
        rst_n = 1;
        tick(5);
        good(8'h29, "post_reset");
        pop("pop_post_reset");
        kdat = 0;
        tick(3);
        kclk = 0;
        tick(FL - 2);
        kclk = 1;
        tick(40);
        kdat = 1;
        tick(20);
        good(8'h1B, "after_glitch");
        pop("pop_glitch");
        send_frame(8'h6B, 0, 5);
        tick(TC / 2);
        check_all("tmo_mid");
        tick(TC);
        err_m = 1;
        check_all("timeout");
        good(8'h29, "after_tmo");
        pop("pop_tmo");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
